// File: rtl/tap_mac_scheduler_pkg.sv
// rtl/tap_mac_scheduler_pkg.sv - shared constants, types and round/saturate helper for the tap MAC scheduler
package tap_mac_scheduler_pkg;

  localparam int FXP_WIDTH     = 16;
  localparam int FXP_FRAC      = 12;
  localparam int FILTER_LENGTH = 8;
  localparam int TAP_BUS_WIDTH = FILTER_LENGTH * FXP_WIDTH;
  localparam int ACC_WIDTH     = 2 * FXP_WIDTH + $clog2(FILTER_LENGTH);
  localparam int IDX_WIDTH     = $clog2(FILTER_LENGTH);

  typedef logic signed [FXP_WIDTH-1:0]   fxp_t;
  typedef logic signed [2*FXP_WIDTH-1:0] prod_t;
  typedef logic signed [ACC_WIDTH-1:0]   acc_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } sched_state_t;

  typedef enum logic {
    GRANT_FF = 1'b0,
    GRANT_FB = 1'b1
  } grant_t;

  localparam acc_t ROUND_HALF  = acc_t'(2 ** (FXP_FRAC - 1));
  localparam acc_t FXP_MAX_ACC = acc_t'(2 ** (FXP_WIDTH - 1) - 1);
  localparam acc_t FXP_MIN_ACC = acc_t'(-(2 ** (FXP_WIDTH - 1)));

  // Round half-up toward +inf, then clamp into the FXP range.
  function automatic fxp_t fxp_round_sat(input acc_t a);
    acc_t r;
    fxp_t y;
    r = (a + ROUND_HALF) >>> FXP_FRAC;
    if (r > FXP_MAX_ACC)
      y = fxp_t'(FXP_MAX_ACC);
    else if (r < FXP_MIN_ACC)
      y = fxp_t'(FXP_MIN_ACC);
    else
      y = fxp_t'(r);
    return y;
  endfunction

endpackage

// File: rtl/tap_mac_scheduler_fxp_mac_unit.sv
// rtl/tap_mac_scheduler_fxp_mac_unit.sv - registered signed multiply, accumulate and round/saturate result
module fxp_mac_unit
  import tap_mac_scheduler_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run_en,
  input  logic drain_en,
  input  fxp_t tap,
  input  fxp_t coef,
  output fxp_t res
);

  prod_t prod;
  acc_t  acc;
  acc_t  acc_sum;

  // The accumulator always folds in the product registered one cycle earlier.
  assign acc_sum = acc + acc_t'(prod);

  // Product pipeline, accumulator and result register; result is captured on the final add.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod <= '0;
      acc  <= '0;
      res  <= '0;
    end else if (clr) begin
      prod <= '0;
      acc  <= '0;
    end else if (run_en) begin
      prod <= prod_t'(tap) * prod_t'(coef);
      acc  <= acc_sum;
    end else if (drain_en) begin
      acc  <= acc_sum;
      res  <= fxp_round_sat(acc_sum);
    end
  end

endmodule

// File: rtl/tap_mac_scheduler.sv
// rtl/tap_mac_scheduler.sv - round-robin arbiter and FSM sharing one FXP MAC between ff and fb dot products
module tap_mac_scheduler
  import tap_mac_scheduler_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ff_req,
  input  logic [TAP_BUS_WIDTH-1:0] ff_taps,
  input  logic [TAP_BUS_WIDTH-1:0] ff_coef,
  input  logic                     fb_req,
  input  logic [TAP_BUS_WIDTH-1:0] fb_taps,
  input  logic [TAP_BUS_WIDTH-1:0] fb_coef,
  output logic                     ff_gnt,
  output logic                     fb_gnt,
  output logic [FXP_WIDTH-1:0]     res_data,
  output logic                     res_id,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     busy
);

  sched_state_t             state;
  sched_state_t             state_next;
  grant_t                   last_grant;
  logic [IDX_WIDTH-1:0]     idx;
  logic [TAP_BUS_WIDTH-1:0] snap_taps;
  logic [TAP_BUS_WIDTH-1:0] snap_coef;
  logic                     pick_ff;
  logic                     pick_fb;
  logic                     mac_clr;
  logic                     mac_run;
  logic                     mac_drain;
  fxp_t                     cur_tap;
  fxp_t                     cur_coef;
  fxp_t                     res_fxp;

  // Round-robin: a lone requester wins, on contention the side not served last wins.
  always_comb begin
    pick_ff = ff_req && (!fb_req || (last_grant == GRANT_FB));
    pick_fb = fb_req && !pick_ff;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  // Next-state logic: RUN lasts exactly FILTER_LENGTH cycles, DONE waits for the consumer.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (ff_req || fb_req) state_next = S_RUN;
      S_RUN:   if (idx == IDX_WIDTH'(FILTER_LENGTH - 1)) state_next = S_DRAIN;
      S_DRAIN: state_next = S_DONE;
      S_DONE:  if (res_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs and MAC controls decoded from state; a grant marks the capture edge at the end of this IDLE cycle.
  always_comb begin
    ff_gnt    = !rst && (state == S_IDLE) && pick_ff;
    fb_gnt    = !rst && (state == S_IDLE) && pick_fb;
    busy      = (state != S_IDLE);
    res_valid = (state == S_DONE);
    mac_clr   = ff_gnt || fb_gnt;
    mac_run   = (state == S_RUN);
    mac_drain = (state == S_DRAIN);
  end

  // Snapshot the granted buses so later history shifts cannot disturb the job; step the tap index.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_taps  <= '0;
      snap_coef  <= '0;
      res_id     <= 1'b0;
      last_grant <= GRANT_FB;
      idx        <= '0;
    end else if (ff_gnt) begin
      snap_taps  <= ff_taps;
      snap_coef  <= ff_coef;
      res_id     <= 1'b0;
      last_grant <= GRANT_FF;
      idx        <= '0;
    end else if (fb_gnt) begin
      snap_taps  <= fb_taps;
      snap_coef  <= fb_coef;
      res_id     <= 1'b1;
      last_grant <= GRANT_FB;
      idx        <= '0;
    end else if (state == S_RUN) begin
      idx        <= idx + 1'b1;
    end
  end

  assign cur_tap  = fxp_t'(snap_taps[idx*FXP_WIDTH +: FXP_WIDTH]);
  assign cur_coef = fxp_t'(snap_coef[idx*FXP_WIDTH +: FXP_WIDTH]);
  assign res_data = res_fxp;

  fxp_mac_unit u_mac (
    .clk      (clk),
    .rst      (rst),
    .clr      (mac_clr),
    .run_en   (mac_run),
    .drain_en (mac_drain),
    .tap      (cur_tap),
    .coef     (cur_coef),
    .res      (res_fxp)
  );

endmodule

// File: tb/tb_tap_mac_scheduler.sv
// tb/tb_tap_mac_scheduler.sv - directed self-checking bench for tap_mac_scheduler
module tb_tap_mac_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         ff_req;
  logic [127:0] ff_taps;
  logic [127:0] ff_coef;
  logic         fb_req;
  logic [127:0] fb_taps;
  logic [127:0] fb_coef;
  logic         ff_gnt;
  logic         fb_gnt;
  logic [15:0]  res_data;
  logic         res_id;
  logic         res_valid;
  logic         res_ready;
  logic         busy;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  tap_mac_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .ff_req    (ff_req),
    .ff_taps   (ff_taps),
    .ff_coef   (ff_coef),
    .fb_req    (fb_req),
    .fb_taps   (fb_taps),
    .fb_coef   (fb_coef),
    .ff_gnt    (ff_gnt),
    .fb_gnt    (fb_gnt),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] b0(input logic signed [15:0] v);
    return {112'b0, v};
  endfunction

  function automatic logic [127:0] ball(input logic signed [15:0] v);
    return {8{v}};
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called one negedge after the grant cycle; lat counts cycles since the grant.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!res_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Wait (bounded) for either grant; who = 0 ff, 1 fb, 2 timeout.
  task automatic wait_gnt(output int who);
    int n;
    n = 0;
    while (!ff_gnt && !fb_gnt && n < 40) begin
      @(negedge clk);
      n++;
    end
    who = ff_gnt ? 0 : (fb_gnt ? 1 : 2);
  endtask

  // One complete single-requester job with res_ready held high; buses are scrambled right after the grant.
  task automatic job(input string tag, input bit use_fb, input logic [127:0] taps,
                     input logic [127:0] coef, input longint exp);
    int lat;
    @(posedge clk); #1;
    res_ready = 1'b1;
    if (use_fb) begin fb_req = 1'b1; fb_taps = taps; fb_coef = coef; end
    else        begin ff_req = 1'b1; ff_taps = taps; ff_coef = coef; end
    @(negedge clk);
    chk({tag, "_gnt"}, use_fb ? fb_gnt : ff_gnt, 1);
    chk({tag, "_other_gnt"}, use_fb ? ff_gnt : fb_gnt, 0);
    @(posedge clk); #1;
    if (use_fb) begin fb_req = 1'b0; fb_taps = ~taps; fb_coef = ~coef; end
    else        begin ff_req = 1'b0; ff_taps = ~taps; ff_coef = ~coef; end
    @(negedge clk);
    chk({tag, "_gnt_pulse"}, ff_gnt | fb_gnt, 0);
    wait_valid(lat);
    chk({tag, "_latency"}, lat, 10);
    chk({tag, "_data"}, $signed(res_data), exp);
    chk({tag, "_id"}, res_id, use_fb);
    @(negedge clk);
    chk({tag, "_valid_drop"}, res_valid, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int lat;
    int who;
    int exp_who;
    rst = 1'b1; ff_req = 1'b0; fb_req = 1'b0; res_ready = 1'b1;
    ff_taps = '0; ff_coef = '0; fb_taps = '0; fb_coef = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_data", res_data, 0);
    chk("rst_id", res_id, 0);
    chk("rst_gnt", ff_gnt | fb_gnt, 0);

    // Basic ff job, saturation both ways, rounding edges
    job("ff_basic", 0, b0(16'sd4096), b0(16'sd8192), 8192);
    job("sat_pos", 1, ball(16'sd4096), ball(16'sd4096), 32767);
    job("sat_neg", 1, ball(-16'sd4096), ball(16'sd4096), -32768);
    job("rnd_half", 0, b0(16'sd1), b0(16'sd2048), 1);
    job("rnd_below", 0, b0(16'sd1), b0(16'sd2047), 0);
    job("rnd_neg_half", 0, b0(-16'sd1), b0(16'sd2048), 0);

    // Arbitration: both held after reset -> ff, fb, ff
    do_reset();
    @(posedge clk); #1;
    ff_req = 1'b1; ff_taps = b0(16'sd4096); ff_coef = b0(16'sd4096);
    fb_req = 1'b1; fb_taps = b0(16'sd4096); fb_coef = b0(16'sd8192);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      exp_who = k % 2;
      wait_gnt(who);
      chk("arb_order", who, exp_who);
      if (k == 2) begin
        @(posedge clk); #1;
        ff_req = 1'b0; fb_req = 1'b0;
      end
      @(negedge clk);
      wait_valid(lat);
      chk("arb_id", res_id, exp_who);
      chk("arb_data", $signed(res_data), (exp_who == 1) ? 8192 : 4096);
    end
    @(negedge clk);
    chk("arb_idle", busy, 0);

    // Backpressure with fb pending; ff buses scrambled after grant
    @(posedge clk); #1;
    res_ready = 1'b0;
    ff_req = 1'b1; ff_taps = b0(16'sd12288); ff_coef = b0(16'sd4096);
    @(negedge clk);
    chk("bp_ff_gnt", ff_gnt, 1);
    @(posedge clk); #1;
    ff_req = 1'b0; ff_taps = ~ff_taps; ff_coef = ~ff_coef;
    fb_req = 1'b1; fb_taps = b0(-16'sd4096); fb_coef = b0(16'sd4096);
    @(negedge clk);
    wait_valid(lat);
    chk("bp_latency", lat, 10);
    chk("bp_data", $signed(res_data), 12288);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", res_valid, 1);
      chk("bp_hold_data", $signed(res_data), 12288);
      chk("bp_hold_id", res_id, 0);
      chk("bp_no_gnt", ff_gnt | fb_gnt, 0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_fb_gnt_after_accept", fb_gnt, 1);
    chk("bp_valid_drop", res_valid, 0);
    @(posedge clk); #1;
    fb_req = 1'b0; fb_taps = ~fb_taps;
    @(negedge clk);
    wait_valid(lat);
    chk("bp_fb_latency", lat, 10);
    chk("bp_fb_data", $signed(res_data), -4096);
    chk("bp_fb_id", res_id, 1);
    @(negedge clk);

    // Reset while RUN at idx 3
    @(posedge clk); #1;
    ff_req = 1'b1; ff_taps = b0(16'sd4096); ff_coef = b0(16'sd4096);
    @(negedge clk);
    chk("mid_rst_gnt", ff_gnt, 1);
    @(posedge clk); #1;
    ff_req = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_data", res_data, 0);
    repeat (12) @(negedge clk);
    chk("mid_rst_no_result", res_valid | busy, 0);
    job("post_rst", 0, b0(16'sd4096), b0(16'sd8192), 8192);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
